// File: rtl/riscv_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and requester grant IDs.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    localparam logic GNT_CORE = 1'b0;
    localparam logic GNT_LD   = 1'b1;

    localparam int WAIT_CNT_W = 3;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way tie-breaker: picks core (a) or loader (b) for the next access.
module rr_pick
    import riscv_pkg::*;
(
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_last,
    input  logic i_prio,
    output logic o_winner
);

    always_comb begin
        o_winner = GNT_CORE;
        if (i_req_a && i_req_b) begin
            // On a tie without fixed priority the requester not served last goes next.
            o_winner = i_prio ? GNT_LD : ~i_last;
        end else if (i_req_b) begin
            o_winner = GNT_LD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory between the core and the loader, one non-pipelined access at a time,
// and doubles as the core stall source by withholding core_ready until the access completes.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int LOADER_PRIO = 0
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ready,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [WAIT_CNT_W-1:0] LAT_M1   = WAIT_CNT_W'(MEM_LATENCY - 1);
    localparam logic                  PRIO_BIT = (LOADER_PRIO != 0);

    arb_state_t              r_state;
    logic                    r_grant;
    logic                    r_last_grant;
    logic                    r_txn_we;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic                    r_mem_en;
    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic [DATA_W-1:0]       r_core_rdata;
    logic [DATA_W-1:0]       r_ld_rdata;
    logic                    r_core_ready;
    logic                    r_ld_ready;
    logic                    r_busy;

    logic                    w_winner;
    logic                    w_sel_we;
    logic [ADDR_W-1:0]       w_sel_addr;
    logic [DATA_W-1:0]       w_sel_wdata;

    rr_pick u_pick (
        .i_req_a  (core_req),
        .i_req_b  (ld_req),
        .i_last   (r_last_grant),
        .i_prio   (PRIO_BIT),
        .o_winner (w_winner)
    );

    assign w_sel_we    = (w_winner == GNT_LD) ? ld_we    : core_we;
    assign w_sel_addr  = (w_winner == GNT_LD) ? ld_addr  : core_addr;
    assign w_sel_wdata = (w_winner == GNT_LD) ? ld_wdata : core_wdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= GNT_CORE;
            r_last_grant <= GNT_LD;
            r_txn_we     <= 1'b0;
            r_wait_cnt   <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_core_rdata <= '0;
            r_ld_rdata   <= '0;
            r_core_ready <= 1'b0;
            r_ld_ready   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Strobes are single-cycle; the state arms them only for the next cycle.
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_core_ready <= 1'b0;
            r_ld_ready   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (core_req || ld_req) begin
                        r_grant     <= w_winner;
                        r_txn_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_sel_we;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_txn_we) begin
                        r_core_ready <= (r_grant == GNT_CORE);
                        r_ld_ready   <= (r_grant == GNT_LD);
                        r_state      <= ST_DONE;
                    end else begin
                        r_wait_cnt <= LAT_M1;
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        if (r_grant == GNT_LD) begin
                            r_ld_rdata <= mem_rdata;
                        end else begin
                            r_core_rdata <= mem_rdata;
                        end
                        r_core_ready <= (r_grant == GNT_CORE);
                        r_ld_ready   <= (r_grant == GNT_LD);
                        r_state      <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_last_grant <= r_grant;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_rdata = r_core_rdata;
    assign core_ready = r_core_ready;
    assign ld_rdata   = r_ld_rdata;
    assign ld_ready   = r_ld_ready;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (latency 1 round-robin, latency 3 round-robin,
// latency 1 loader-priority), each with a latency-exact memory model and a shared scoreboard.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic [N-1:0] core_req, core_we, core_ready, ld_req, ld_we, ld_ready;
    logic [N-1:0] mem_en, mem_we, busy;
    logic [31:0]  core_addr [N];
    logic [31:0]  core_wdata[N];
    logic [31:0]  core_rdata[N];
    logic [31:0]  ld_addr   [N];
    logic [31:0]  ld_wdata  [N];
    logic [31:0]  ld_rdata  [N];
    logic [31:0]  mem_addr  [N];
    logic [31:0]  mem_wdata [N];
    logic [31:0]  mem_rdata [N];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return {~lo, lo};
    endfunction

    function automatic bit prio_of(input int k);
        return (k == 2);
    endfunction

    // Memory model: read data is valid only in the exact cycle MEM_LATENCY after mem_en.
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        localparam int L = (gi == 1) ? 3 : 1;
        logic [7:0]  pipe_v = '0;
        logic [31:0] pipe_a [8];
        always @(posedge clk) begin
            pipe_v    <= {pipe_v[6:0], mem_en[gi] & ~mem_we[gi]};
            pipe_a[0] <= mem_addr[gi];
            for (int j = 1; j < 8; j++) pipe_a[j] <= pipe_a[j-1];
        end
        assign mem_rdata[gi] = pipe_v[L-1] ? data_fn(pipe_a[L-1]) : 32'hBAD0_BAD0;

        mem_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .LOADER_PRIO((gi == 2) ? 1 : 0)
        ) u_dut (
            .clk(clk), .reset_n(reset_n),
            .core_req(core_req[gi]), .core_we(core_we[gi]), .core_addr(core_addr[gi]),
            .core_wdata(core_wdata[gi]), .core_rdata(core_rdata[gi]), .core_ready(core_ready[gi]),
            .ld_req(ld_req[gi]), .ld_we(ld_we[gi]), .ld_addr(ld_addr[gi]),
            .ld_wdata(ld_wdata[gi]), .ld_rdata(ld_rdata[gi]), .ld_ready(ld_ready[gi]),
            .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
            .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi]), .busy(busy[gi])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        int          inst;
        bit          is_ld;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          issue;
        int          lat;
    } exp_t;

    typedef struct {
        int          inst;
        bit          is_ld;
        bit          we;
        bit          drop;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   en_cnt  [N];
    int   busy_cnt[N];
    bit   last_g  [N];

    // Monitor: compares every memory strobe and ready pulse against the scoreboard front.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            chk("mem_we_without_en", {31'd0, mem_we[k] & ~mem_en[k]}, 32'd0);
            if (busy[k]) busy_cnt[k]++;
            if (mem_en[k]) begin
                en_cnt[k]++;
                if (sbq.size() == 0) begin
                    chk("mem_en_unexpected", {31'd0, mem_en[k]}, 32'd0);
                end else begin
                    chk("mem_inst", 32'(k), 32'(sbq[0].inst));
                    chk("mem_addr", mem_addr[k], sbq[0].addr);
                    chk("mem_we", {31'd0, mem_we[k]}, {31'd0, sbq[0].we});
                    if (sbq[0].we) chk("mem_wdata", mem_wdata[k], sbq[0].wdata);
                end
            end
            if (core_ready[k] || ld_ready[k]) begin
                if (sbq.size() == 0) begin
                    chk("ready_unexpected", {30'd0, core_ready[k], ld_ready[k]}, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("ready_inst", 32'(k), 32'(mon_e.inst));
                    chk("core_ready", {31'd0, core_ready[k]}, {31'd0, ~mon_e.is_ld});
                    chk("ld_ready", {31'd0, ld_ready[k]}, {31'd0, mon_e.is_ld});
                    if (!mon_e.we)
                        chk("rdata", mon_e.is_ld ? ld_rdata[k] : core_rdata[k], mon_e.rdata);
                    chk("latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
                    last_g[k] = mon_e.is_ld;
                    $display("txn inst%0d %s %s addr=0x%08h data=0x%08h lat=%0d", k,
                             mon_e.is_ld ? "LD  " : "CORE", mon_e.we ? "WR" : "RD", mon_e.addr,
                             mon_e.we ? mon_e.wdata : (mon_e.is_ld ? ld_rdata[k] : core_rdata[k]),
                             cyc - mon_e.issue);
                end
            end
        end
    end

    task automatic drive(input int k, input bit is_ld, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (is_ld) begin
            ld_req[k] = req; ld_we[k] = we; ld_addr[k] = addr; ld_wdata[k] = wdata;
        end else begin
            core_req[k] = req; core_we[k] = we; core_addr[k] = addr; core_wdata[k] = wdata;
        end
    endtask

    // Single transaction from an idle arbiter; entered and left on a falling edge.
    task automatic run_txn(input vec_t v);
        exp_t e;
        int   waited;
        int   k;
        k       = v.inst;
        e.inst  = k;       e.is_ld = v.is_ld;  e.we    = v.we;
        e.addr  = v.addr;  e.wdata = v.wdata;  e.rdata = v.exp_rdata;
        e.issue = cyc;     e.lat   = v.exp_lat;
        en_cnt[k]   = 0;
        busy_cnt[k] = 0;
        sbq.push_back(e);
        drive(k, v.is_ld, 1'b1, v.we, v.addr, v.wdata);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            if (v.drop) drive(k, v.is_ld, 1'b0, v.we, v.addr, v.wdata);
        end while (!(core_ready[k] || ld_ready[k]) && waited < 20);
        if (!(core_ready[k] || ld_ready[k])) begin
            chk("ready_timeout", {31'd0, core_ready[k] | ld_ready[k]}, 32'd1);
            sbq.delete();
        end
        drive(k, v.is_ld, 1'b0, v.we, v.addr, v.wdata);
        @(negedge clk);
        chk("mem_en_count", 32'(en_cnt[k]), 32'd1);
        chk("busy_cycles", 32'(busy_cnt[k]), 32'(v.exp_lat));
        chk("busy_after", {31'd0, busy[k]}, 32'd0);
    endtask

    // Both requesters held high; the expected grant order comes from the tie rule model.
    task automatic tie_seq(input int k, input int n_txn);
        exp_t e;
        bit   lg;
        int   base;
        int   got;
        int   waited;
        lg   = last_g[k];
        base = cyc;
        for (int i = 0; i < n_txn; i++) begin
            if (prio_of(k)) e.is_ld = (i < n_txn - 1);
            else            e.is_ld = ~lg;
            lg      = e.is_ld;
            e.inst  = k;
            e.we    = 1'b1;
            e.addr  = e.is_ld ? 32'h0000_0300 : 32'h0000_0200;
            e.wdata = e.is_ld ? 32'h1D1D_0000 + 32'(k) : 32'hC0C0_0000 + 32'(k);
            e.rdata = '0;
            e.issue = base + 3 * i;
            e.lat   = 2;
            sbq.push_back(e);
        end
        drive(k, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 32'hC0C0_0000 + 32'(k));
        drive(k, 1'b1, 1'b1, 1'b1, 32'h0000_0300, 32'h1D1D_0000 + 32'(k));
        got    = 0;
        waited = 0;
        while (got < n_txn && waited < 60) begin
            @(negedge clk);
            waited++;
            if (core_ready[k] || ld_ready[k]) got++;
            if (prio_of(k) && got == n_txn - 1) ld_req[k] = 1'b0;
        end
        core_req[k] = 1'b0;
        ld_req[k]   = 1'b0;
        if (got < n_txn) begin
            chk("tie_timeout", 32'(got), 32'(n_txn));
            sbq.delete();
        end
        @(negedge clk);
    endtask

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        tbl[0] = '{0, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 3};
        tbl[1] = '{0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0050_0093, 32'h0,          2};
        tbl[2] = '{0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,          32'hFFBF_0040, 3};
        tbl[3] = '{0, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h1234_5678, 32'h0,          2};
        tbl[4] = '{0, 1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h0,          32'hFFBB_0044, 3};
        tbl[5] = '{1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 5};
        tbl[6] = '{1, 1'b1, 1'b0, 1'b0, 32'h0000_0024, 32'h0,          32'hFFDB_0024, 5};
        tbl[7] = '{1, 1'b0, 1'b1, 1'b0, 32'h0000_0060, 32'hCAFE_F00D, 32'h0,          2};
        tbl[8] = '{2, 1'b0, 1'b0, 1'b0, 32'h0000_001C, 32'h0,          32'hFFE3_001C, 3};
        tbl[9] = '{2, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'hA5A5_5A5A, 32'h0,          2};

        reset_n  = 1'b0;
        core_req = '1;  core_we = '0;  ld_req = '0;  ld_we = '0;
        for (int k = 0; k < N; k++) begin
            core_addr[k] = 32'h0000_0010; core_wdata[k] = '0;
            ld_addr[k]   = '0;            ld_wdata[k]   = '0;
            last_g[k]    = 1'b1;
            en_cnt[k]    = 0;
            busy_cnt[k]  = 0;
        end

        // Reset held two cycles with the core requesting: nothing may start.
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                chk("rst_mem_en", {31'd0, mem_en[k]}, 32'd0);
                chk("rst_core_ready", {31'd0, core_ready[k]}, 32'd0);
                chk("rst_busy", {31'd0, busy[k]}, 32'd0);
            end
        end
        chk("rst_core_rdata", core_rdata[0], 32'd0);
        chk("rst_mem_addr", mem_addr[0], 32'd0);
        core_req = '0;
        reset_n  = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_txn(tbl[i]);

        // Non-granted requester keeps its last captured read data.
        chk("hold_ld_rdata", ld_rdata[0], 32'hFFBF_0040);
        chk("hold_core_rdata", core_rdata[0], 32'hFFBB_0044);

        tie_seq(0, 4);
        tie_seq(2, 4);

        // Reset asserted while instance 1 waits on a read: no ready may follow.
        e = '{1, 1'b0, 1'b0, 32'h0000_0050, 32'h0, 32'hFFAF_0050, cyc, 5};
        sbq.push_back(e);
        drive(1, 1'b0, 1'b1, 1'b0, 32'h0000_0050, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("wait_busy", {31'd0, busy[1]}, 32'd1);
        sbq.delete();
        reset_n     = 1'b0;
        core_req[1] = 1'b0;
        @(negedge clk);
        chk("rstw_busy", {31'd0, busy[1]}, 32'd0);
        chk("rstw_ready", {31'd0, core_ready[1]}, 32'd0);
        chk("rstw_mem_en", {31'd0, mem_en[1]}, 32'd0);
        chk("rstw_rdata", core_rdata[1], 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) last_g[k] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rstw_no_ready", {31'd0, core_ready[1]}, 32'd0);
        end
        run_txn('{1, 1'b0, 1'b0, 1'b0, 32'h0000_0050, 32'h0, 32'hFFAF_0050, 5});

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
